// File: rtl/sliding_window_same_pad.sv
// Same-padded sliding-window generator: one WINDOW_SIZE x WINDOW_SIZE x CHANNELS window per input pixel.
// Optional tlast cross-check enabled by the SLIDING_WINDOW_TLAST_CHECK_EN macro.
module sliding_window_same_pad #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 3,
    parameter int WINDOW_SIZE = 3,
    parameter int HEIGHT      = 600,
    parameter int WIDTH       = 800
) (
    input  logic                                                  clock_i,
    input  logic                                                  reset_ni,
    input  logic                                                  slave_tvalid_i,
    output logic                                                  slave_tready_o,
    input  logic [CHANNELS*DATA_WIDTH-1:0]                        slave_tdata_i,
    input  logic                                                  slave_tlast_i,
    output logic                                                  master_tvalid_o,
    input  logic                                                  master_tready_i,
    output logic [WINDOW_SIZE*WINDOW_SIZE*CHANNELS*DATA_WIDTH-1:0] master_tdata_o,
    output logic                                                  master_tlast_o,
    output logic                                                  frame_error_o
);

    localparam int PAD     = (WINDOW_SIZE - 1) / 2;
    localparam int PIX_W   = CHANNELS * DATA_WIDTH;
    localparam int WIN_W   = WINDOW_SIZE * WINDOW_SIZE * PIX_W;
    localparam int LB_ROWS = WINDOW_SIZE - 1;
    localparam int ROW_W   = $clog2(HEIGHT + PAD);
    localparam int COL_W   = $clog2(WIDTH + PAD);
    localparam int ADDR_W  = $clog2(WIDTH);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT + PAD - 1);
    localparam logic [ROW_W-1:0] ROW_LIM  = ROW_W'(HEIGHT);
    localparam logic [ROW_W-1:0] ROW_PADV = ROW_W'(PAD);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH + PAD - 1);
    localparam logic [COL_W-1:0] COL_LIM  = COL_W'(WIDTH);
    localparam logic [COL_W-1:0] COL_PADV = COL_W'(PAD);

    typedef enum logic [1:0] {
        ST_STREAM  = 2'd0,
        ST_ROW_PAD = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [ROW_W-1:0]    vr_r;
    logic [ROW_W-1:0]    vr_nx_s;
    logic [COL_W-1:0]    vc_r;
    logic [COL_W-1:0]    vc_nx_s;
    logic                slot_free_s;
    logic                adv_s;
    logic                ready_s;
    logic                produce_s;
    logic                last_pos_s;
    logic                err_s;

    logic                out_valid_r;
    logic [WIN_W-1:0]    out_data_r;
    logic                out_last_r;
    logic                err_r;

    logic [PIX_W-1:0]    lb_r  [0:LB_ROWS-1][0:WIDTH-1];
    logic [PIX_W-1:0]    rd_r  [0:LB_ROWS-1];
    logic [PIX_W-1:0]    sr_r  [0:WINDOW_SIZE-2][0:WINDOW_SIZE-1];
    logic [PIX_W-1:0]    col_s [0:WINDOW_SIZE-1];
    logic [WIN_W-1:0]    win_s;

    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic                rd_en_s;
    logic [ADDR_W-1:0]   rd_addr_s;

    int                  src_row_s;
    int                  src_col_s;
    logic [PIX_W-1:0]    tap_s;

    // Advance decision, scan-position successor and FSM next state
    always_comb begin
        state_nx_s  = state_r;
        vr_nx_s     = vr_r;
        vc_nx_s     = vc_r;
        ready_s     = 1'b0;
        adv_s       = 1'b0;
        slot_free_s = !out_valid_r || master_tready_i;
        case (state_r)
            ST_STREAM: begin
                ready_s = slot_free_s;
                adv_s   = slot_free_s && slave_tvalid_i;
            end
            ST_ROW_PAD: adv_s = slot_free_s;
            ST_FLUSH:   adv_s = slot_free_s;
            default:    adv_s = 1'b0;
        endcase
        if (!reset_ni) begin
            ready_s = 1'b0;
            adv_s   = 1'b0;
        end else begin
            ready_s = ready_s;
        end
        if (adv_s) begin
            if (vc_r == COL_LAST) begin
                vc_nx_s = {COL_W{1'b0}};
                if (vr_r == ROW_LAST) begin
                    vr_nx_s = {ROW_W{1'b0}};
                end else begin
                    vr_nx_s = vr_r + 1'b1;
                end
            end else begin
                vc_nx_s = vc_r + 1'b1;
                vr_nx_s = vr_r;
            end
            if (vr_nx_s >= ROW_LIM) begin
                state_nx_s = ST_FLUSH;
            end else if (vc_nx_s >= COL_LIM) begin
                state_nx_s = ST_ROW_PAD;
            end else begin
                state_nx_s = ST_STREAM;
            end
        end else begin
            state_nx_s = state_r;
        end
    end

    assign slave_tready_o = ready_s;
    assign produce_s  = adv_s && (vr_r >= ROW_PADV) && (vc_r >= COL_PADV);
    assign last_pos_s = (vr_r == ROW_LAST) && (vc_r == COL_LAST);

    // Scan position and FSM state register
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_r <= ST_STREAM;
            vr_r    <= {ROW_W{1'b0}};
            vc_r    <= {COL_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            vr_r    <= vr_nx_s;
            vc_r    <= vc_nx_s;
        end
    end

    // Newest column: line-buffer rows on top, live pixel (or zero outside STREAM) at the bottom
    always_comb begin
        for (int i = 0; i < WINDOW_SIZE - 1; i++) begin
            col_s[i] = rd_r[WINDOW_SIZE-2-i];
        end
        if (state_r == ST_STREAM) begin
            col_s[WINDOW_SIZE-1] = slave_tdata_i;
        end else begin
            col_s[WINDOW_SIZE-1] = {PIX_W{1'b0}};
        end
    end

    // Line buffers are written once per real column and read one position ahead
    always_comb begin
        wr_en_s   = adv_s && (vc_r < COL_LIM);
        wr_addr_s = ADDR_W'(vc_r);
        rd_en_s   = adv_s || !reset_ni;
        if (!reset_ni || (vc_nx_s >= COL_LIM)) begin
            rd_addr_s = {ADDR_W{1'b0}};
        end else begin
            rd_addr_s = ADDR_W'(vc_nx_s);
        end
    end

    // Line buffer storage: each written column pushes its rows one buffer deeper
    always_ff @(posedge clock_i) begin
        if (wr_en_s) begin
            lb_r[0][wr_addr_s] <= col_s[WINDOW_SIZE-1];
            for (int m = 1; m < LB_ROWS; m++) begin
                lb_r[m][wr_addr_s] <= rd_r[m-1];
            end
        end
    end

    // Registered line-buffer read port; held while the scan is stalled
    always_ff @(posedge clock_i) begin
        if (rd_en_s) begin
            for (int m = 0; m < LB_ROWS; m++) begin
                rd_r[m] <= lb_r[m][rd_addr_s];
            end
        end
    end

    // Column shift register holding the WINDOW_SIZE-1 older columns
    always_ff @(posedge clock_i) begin
        if (adv_s) begin
            for (int j = 0; j < WINDOW_SIZE - 2; j++) begin
                for (int i = 0; i < WINDOW_SIZE; i++) begin
                    sr_r[j][i] <= sr_r[j+1][i];
                end
            end
            for (int i = 0; i < WINDOW_SIZE; i++) begin
                sr_r[WINDOW_SIZE-2][i] <= col_s[i];
            end
        end
    end

    // Window assembly; taps outside the frame are forced to zero whatever the storage holds
    always_comb begin
        win_s     = {WIN_W{1'b0}};
        src_row_s = 0;
        src_col_s = 0;
        tap_s     = {PIX_W{1'b0}};
        for (int i = 0; i < WINDOW_SIZE; i++) begin
            for (int j = 0; j < WINDOW_SIZE; j++) begin
                src_row_s = int'(vr_r) + i - 2 * PAD;
                src_col_s = int'(vc_r) + j - 2 * PAD;
                if ((src_row_s >= 0) && (src_row_s < HEIGHT) &&
                    (src_col_s >= 0) && (src_col_s < WIDTH)) begin
                    if (j == WINDOW_SIZE - 1) begin
                        tap_s = col_s[i];
                    end else begin
                        tap_s = sr_r[j][i];
                    end
                end else begin
                    tap_s = {PIX_W{1'b0}};
                end
                win_s[(i*WINDOW_SIZE+j)*PIX_W +: PIX_W] = tap_s;
            end
        end
    end

`ifdef SLIDING_WINDOW_TLAST_CHECK_EN
    logic accept_s;
    logic last_pix_s;
    assign accept_s   = adv_s && (state_r == ST_STREAM);
    assign last_pix_s = (vr_r == ROW_W'(HEIGHT - 1)) && (vc_r == COL_W'(WIDTH - 1));
    assign err_s      = accept_s && (slave_tlast_i != last_pix_s);
`else
    logic unused_tlast_s;
    assign unused_tlast_s = slave_tlast_i;
    assign err_s          = 1'b0;
`endif

    // Output slot: loads on a producing advance, otherwise empties when drained
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIN_W{1'b0}};
            out_last_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if (produce_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= win_s;
                out_last_r  <= last_pos_s;
            end else if (master_tready_i) begin
                out_valid_r <= 1'b0;
            end
            err_r <= err_s;
        end
    end

    assign master_tvalid_o = out_valid_r;
    assign master_tdata_o  = out_data_r;
    assign master_tlast_o  = out_last_r;
    assign frame_error_o   = err_r;

endmodule

// File: tb/tb_sliding_window_same_pad.sv
// Directed bench for sliding_window_same_pad: scoreboard of model windows, compared as the DUT drains them.
module tb_sliding_window_same_pad;

    localparam int H   = 4;
    localparam int W   = 5;
    localparam int WS  = 3;
    localparam int CH  = 2;
    localparam int DW  = 8;
    localparam int PAD = (WS - 1) / 2;
    localparam int PW  = CH * DW;
    localparam int WW  = WS * WS * PW;
    localparam int NPIX = H * W;
`ifdef SLIDING_WINDOW_TLAST_CHECK_EN
    localparam int EXP_ERRS = 2;
`else
    localparam int EXP_ERRS = 0;
`endif

    logic          clock_i = 1'b0;
    logic          reset_ni;
    logic          slave_tvalid_i;
    logic          slave_tready_o;
    logic [PW-1:0] slave_tdata_i;
    logic          slave_tlast_i;
    logic          master_tvalid_o;
    logic          master_tready_i;
    logic [WW-1:0] master_tdata_o;
    logic          master_tlast_o;
    logic          frame_error_o;

    int tests;
    int failed;
    int err_seen;
    int win_cnt;
    int cur_idx;
    logic monitor_en;
    logic exp_err;
    logic in_acc;
    logic out_acc;
    logic rdy;
    logic [WW-1:0] first_win;
    logic [WW-1:0] exp_data_q[$];
    logic          exp_last_q[$];

    sliding_window_same_pad #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .WINDOW_SIZE(WS),
        .HEIGHT     (H),
        .WIDTH      (W)
    ) dut (
        .clock_i        (clock_i),
        .reset_ni       (reset_ni),
        .slave_tvalid_i (slave_tvalid_i),
        .slave_tready_o (slave_tready_o),
        .slave_tdata_i  (slave_tdata_i),
        .slave_tlast_i  (slave_tlast_i),
        .master_tvalid_o(master_tvalid_o),
        .master_tready_i(master_tready_i),
        .master_tdata_o (master_tdata_o),
        .master_tlast_o (master_tlast_o),
        .frame_error_o  (frame_error_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [PW-1:0] model_pix(input int idx);
        logic [PW-1:0] p;
        int r;
        int c;
        r = idx / W;
        c = idx % W;
        for (int k = 0; k < CH; k++) p[k*DW +: DW] = 8'(16 * r + c + 128 * k);
        return p;
    endfunction

    function automatic logic [WW-1:0] model_win(input int r, input int c);
        logic [WW-1:0] w;
        int sr;
        int sc;
        w = '0;
        for (int i = 0; i < WS; i++) begin
            for (int j = 0; j < WS; j++) begin
                sr = r - PAD + i;
                sc = c - PAD + j;
                if (sr >= 0 && sr < H && sc >= 0 && sc < W) begin
                    for (int k = 0; k < CH; k++)
                        w[((i * WS + j) * CH + k) * DW +: DW] = 8'(16 * sr + sc + 128 * k);
                end
            end
        end
        return w;
    endfunction

    // One clock: sample everything at the falling edge, then return just after the rising edge.
    task automatic step();
        @(negedge clock_i);
        rdy     = slave_tready_o;
        in_acc  = slave_tvalid_i && slave_tready_o;
        out_acc = master_tvalid_o && master_tready_i;
        tests++;
        assert (frame_error_o === exp_err) else begin
            failed++;
            $error("FAIL frame_error got %0b expected %0b", frame_error_o, exp_err);
        end
        if (frame_error_o === 1'b1) err_seen++;
        if (monitor_en && master_tvalid_o === 1'b1) begin
            tests++;
            assert (exp_data_q.size() != 0) else begin
                failed++;
                $error("FAIL extra_window got tdata %h expected no window", master_tdata_o);
            end
            if (exp_data_q.size() != 0) begin
                tests++;
                assert (master_tdata_o === exp_data_q[0]) else begin
                    failed++;
                    $error("FAIL window_data #%0d got %h expected %h", win_cnt, master_tdata_o, exp_data_q[0]);
                end
                tests++;
                assert (master_tlast_o === exp_last_q[0]) else begin
                    failed++;
                    $error("FAIL window_tlast #%0d got %0b expected %0b", win_cnt, master_tlast_o, exp_last_q[0]);
                end
                if (out_acc) begin
                    if (win_cnt == 0) first_win = master_tdata_o;
                    void'(exp_data_q.pop_front());
                    void'(exp_last_q.pop_front());
                    win_cnt++;
                end
            end
        end
`ifdef SLIDING_WINDOW_TLAST_CHECK_EN
        exp_err = in_acc && (slave_tlast_i != (cur_idx == NPIX - 1));
`else
        exp_err = 1'b0;
`endif
        @(posedge clock_i);
        #1;
    endtask

    task automatic run_frames(input int nfr, input int vpct, input int rpct, input bit gaps, input bit bad_tlast);
        int total;
        int acc;
        int cyc;
        int low_run;
        int last_idx;
        int exp_gap;
        total = nfr * NPIX;
        acc = 0;
        cyc = 0;
        low_run = 0;
        last_idx = 0;
        for (int f = 0; f < nfr; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    exp_data_q.push_back(model_win(r, c));
                    exp_last_q.push_back((r == H - 1) && (c == W - 1));
                end
        win_cnt = 0;
        monitor_en = 1'b1;
        slave_tvalid_i = 1'b0;
        while ((acc < total || exp_data_q.size() != 0) && cyc < 4000) begin
            cur_idx = acc % NPIX;
            if (acc >= total) slave_tvalid_i = 1'b0;
            else if (!slave_tvalid_i) slave_tvalid_i = (int'($urandom_range(0, 99)) < vpct);
            slave_tdata_i = model_pix(cur_idx);
            slave_tlast_i = bad_tlast ? (cur_idx == NPIX - 2) : (cur_idx == NPIX - 1);
            master_tready_i = (int'($urandom_range(0, 99)) < rpct);
            step();
            if (gaps) begin
                if (!rdy) low_run++;
                else begin
                    if (low_run > 0) begin
                        exp_gap = ((last_idx / W) == H - 1) ? 1 + PAD * (W + PAD) : 1;
                        tests++;
                        assert (low_run == exp_gap) else begin
                            failed++;
                            $error("FAIL tready_gap after pixel %0d got %0d expected %0d", last_idx, low_run, exp_gap);
                        end
                    end
                    low_run = 0;
                end
            end
            if (in_acc) begin
                last_idx = cur_idx;
                acc++;
                slave_tvalid_i = 1'b0;
            end
            cyc++;
        end
        tests++;
        assert (acc == total && exp_data_q.size() == 0) else begin
            failed++;
            $error("FAIL frame_timeout beats %0d/%0d windows left %0d", acc, total, exp_data_q.size());
        end
        tests++;
        assert (win_cnt == total) else begin
            failed++;
            $error("FAIL window_count got %0d expected %0d", win_cnt, total);
        end
        exp_data_q.delete();
        exp_last_q.delete();
        slave_tvalid_i = 1'b0;
        slave_tlast_i = 1'b0;
        master_tready_i = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        int n;
        int guard;
        tests = 0;
        failed = 0;
        err_seen = 0;
        win_cnt = 0;
        cur_idx = 0;
        monitor_en = 1'b0;
        exp_err = 1'b0;
        first_win = '0;
        reset_ni = 1'b0;
        slave_tvalid_i = 1'b0;
        slave_tdata_i = '0;
        slave_tlast_i = 1'b0;
        master_tready_i = 1'b0;
        repeat (3) @(posedge clock_i);
        #1;
        tests++;
        assert (master_tvalid_o === 1'b0 && master_tlast_o === 1'b0 && frame_error_o === 1'b0) else begin
            failed++;
            $error("FAIL reset_flags got v%0b l%0b e%0b expected all 0", master_tvalid_o, master_tlast_o, frame_error_o);
        end
        tests++;
        assert (master_tdata_o === '0) else begin
            failed++;
            $error("FAIL reset_tdata got %h expected 0", master_tdata_o);
        end
        tests++;
        assert (slave_tready_o === 1'b0) else begin
            failed++;
            $error("FAIL reset_tready got %0b expected 0", slave_tready_o);
        end
        reset_ni = 1'b1;
        #1;
        tests++;
        assert (slave_tready_o === 1'b1) else begin
            failed++;
            $error("FAIL release_tready got %0b expected 1", slave_tready_o);
        end

        // Scenario 1: single frame, downstream always ready
        run_frames(1, 100, 100, 1'b0, 1'b0);
        tests++;
        assert (first_win[47:0] === 48'h0) else begin
            failed++;
            $error("FAIL first_top_row got %h expected 0", first_win[47:0]);
        end
        tests++;
        assert (first_win[79:64] === 16'h8000) else begin
            failed++;
            $error("FAIL first_centre got %h expected 8000", first_win[79:64]);
        end
        tests++;
        assert (first_win[135:128] === 8'h11) else begin
            failed++;
            $error("FAIL first_tap22 got %h expected 11", first_win[135:128]);
        end

        // Scenario 2: back-to-back frames with continuous tvalid
        run_frames(2, 100, 100, 1'b1, 1'b0);

        // Scenario 3: random backpressure and random source gaps
        run_frames(1, 60, 50, 1'b0, 1'b0);
        run_frames(1, 80, 30, 1'b0, 1'b0);

        // Scenario 4: reset after 7 accepted beats, then a full frame
        monitor_en = 1'b0;
        master_tready_i = 1'b1;
        n = 0;
        guard = 0;
        while (n < 7 && guard < 100) begin
            cur_idx = n;
            slave_tvalid_i = 1'b1;
            slave_tdata_i = model_pix(n);
            slave_tlast_i = 1'b0;
            step();
            if (in_acc) n++;
            guard++;
        end
        tests++;
        assert (n == 7) else begin
            failed++;
            $error("FAIL partial_beats got %0d expected 7", n);
        end
        reset_ni = 1'b0;
        slave_tdata_i = model_pix(0);
        step();
        tests++;
        assert (in_acc === 1'b0) else begin
            failed++;
            $error("FAIL accept_in_reset got %0b expected 0", in_acc);
        end
        tests++;
        assert (master_tvalid_o === 1'b0 && master_tdata_o === '0 && master_tlast_o === 1'b0) else begin
            failed++;
            $error("FAIL midframe_reset got v%0b l%0b expected v0 l0 data 0", master_tvalid_o, master_tlast_o);
        end
        reset_ni = 1'b1;
        slave_tvalid_i = 1'b0;
        run_frames(1, 100, 100, 1'b0, 1'b0);

        // Scenario 5: tlast early on pixel (3,3) and missing on (3,4)
        err_seen = 0;
        run_frames(1, 100, 100, 1'b0, 1'b1);
        tests++;
        assert (err_seen == EXP_ERRS) else begin
            failed++;
            $error("FAIL frame_error_pulses got %0d expected %0d", err_seen, EXP_ERRS);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
